// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and helpers for the instruction-memory program loader.
//   loader_state_t  : loader FSM states
//   BYTES_PER_WORD  : bytes per assembled 32-bit word
//   shift_in_byte() : little-endian word assembly step
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        LOAD  = 3'd1,
        CSUM  = 3'd2,
        HOLD  = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Bytes arrive least-significant first. Each new byte enters at the top,
    // so after four bytes the first one has moved down to bits 7:0.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                  input logic [7:0]  b);
        return {b, word[31:8]};
    endfunction

endpackage

// File: rtl/loader_byte_packer.sv
// -----------------------------------------------------------------------------
// loader_byte_packer
// Collects accepted stream bytes into little-endian 32-bit words.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clear_i         : drop any partial word and restart at byte 0
//   byte_vld_i      : a byte is accepted this cycle
//   byte_i          : the accepted byte
//   word_o          : assembled word (valid together with word_valid_o)
//   word_valid_o    : 1-cycle pulse in the cycle the 4th byte is accepted
// -----------------------------------------------------------------------------
module loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   sh_q, sh_d;
    logic [31:0]   assembled;

    // The word is presented combinationally with the final byte so the
    // parent can register the write strobe on that same edge.
    assign assembled    = shift_in_byte(sh_q, byte_i);
    assign word_o       = assembled;
    assign word_valid_o = byte_vld_i && !clear_i &&
                          (cnt_q == CW'(BYTES_PER_WORD - 1));

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clear_i) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (byte_vld_i) begin
            cnt_d = cnt_q + CW'(1);
            sh_d  = assembled;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
// Loads a program into the core's instruction memory from a byte stream and
// keeps the core in reset until the program is complete.
// Stream format: 4-byte LE word count N, then N LE instruction words.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing 4-byte LE
// checksum (mod-2^32 sum of all words); a mismatch lands in ERROR.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   s_valid/s_data/s_ready : byte stream handshake
//   reload       : pulse; restarts loading from RUN or ERROR
//   dbg_wr_en/dbg_addr/dbg_instr : instruction-memory write port
//   cpu_rst      : core reset, high except in RUN
//   load_done    : high in RUN
//   load_err     : high in ERROR
// -----------------------------------------------------------------------------
module imem_program_loader
    import imem_loader_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          MAX_WORDS = 1024,
    parameter int          RST_HOLD  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    input  logic [7:0]      s_data,
    output logic            s_ready,
    input  logic            reload,
    output logic            dbg_wr_en,
    output logic [XLEN-1:0] dbg_addr,
    output logic [XLEN-1:0] dbg_instr,
    output logic            cpu_rst,
    output logic            load_done,
    output logic            load_err
);

    localparam int              WCW   = $clog2(MAX_WORDS + 1);
    localparam int              HCW   = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [XLEN-1:0] BASE  = XLEN'(BASE_ADDR);
    localparam logic [31:0]     MAX_N = 32'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_LOAD = CSUM;
`else
    localparam loader_state_t AFTER_LOAD = HOLD;
`endif

    loader_state_t   state_q, state_d;
    logic [WCW-1:0]  n_q, n_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [HCW-1:0]  hold_q, hold_d;
    logic            s_ready_q, s_ready_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            wr_en_q, wr_en_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]     csum_q, csum_d;
`endif

    logic            byte_acc;
    logic            pk_clear;
    logic [31:0]     pk_word;
    logic            pk_valid;

    // s_ready_q only ever is 1 in HDR/LOAD/CSUM, so no state gating needed.
    assign byte_acc = s_valid && s_ready_q;

    loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (pk_clear),
        .byte_vld_i   (byte_acc),
        .byte_i       (s_data),
        .word_o       (pk_word),
        .word_valid_o (pk_valid)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        wcnt_d   = wcnt_q;
        hold_d   = hold_q;
        wr_en_d  = 1'b0;
        addr_d   = addr_q;
        instr_d  = instr_q;
        pk_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif

        case (state_q)
            HDR: begin
`ifdef LOADER_CHECKSUM_EN
                csum_d = '0;
`endif
                if (pk_valid) begin
                    if (pk_word > MAX_N) begin
                        state_d = ERROR;
                    end else begin
                        n_d     = pk_word[WCW-1:0];
                        state_d = (pk_word == 32'd0) ? AFTER_LOAD : LOAD;
                    end
                end
            end

            LOAD: begin
                if (pk_valid) begin
                    wr_en_d = 1'b1;
                    instr_d = XLEN'(pk_word);
                    // Address wraps modulo 2^XLEN by construction.
                    addr_d  = BASE + (XLEN'(wcnt_q) << 2);
                    wcnt_d  = wcnt_q + WCW'(1);
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q + pk_word;
`endif
                    if (wcnt_d == n_q) state_d = AFTER_LOAD;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (pk_valid) state_d = (pk_word == csum_q) ? HOLD : ERROR;
            end
`endif

            // First HOLD cycle is the cycle of the final write strobe, so
            // RUN begins exactly RST_HOLD cycles after that strobe.
            HOLD: begin
                if (hold_q == HCW'(RST_HOLD - 1)) state_d = RUN;
                else                              hold_d  = hold_q + HCW'(1);
            end

            RUN, ERROR: begin
                if (reload) begin
                    state_d  = HDR;
                    n_d      = '0;
                    wcnt_d   = '0;
                    hold_d   = '0;
                    addr_d   = BASE;
                    pk_clear = 1'b1;
                end
            end

            default: state_d = HDR;
        endcase

        // Outputs are registered off the next state so they line up with it.
        s_ready_d = (state_d == HDR) || (state_d == LOAD) || (state_d == CSUM);
        cpu_rst_d = (state_d != RUN);
        done_d    = (state_d == RUN);
        err_d     = (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HDR;
            n_q       <= '0;
            wcnt_q    <= '0;
            hold_q    <= '0;
            s_ready_q <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= BASE;
            instr_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            wcnt_q    <= wcnt_d;
            hold_q    <= hold_d;
            s_ready_q <= s_ready_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign s_ready   = s_ready_q;
    assign cpu_rst   = cpu_rst_q;
    assign load_done = done_q;
    assign load_err  = err_q;
    assign dbg_wr_en = wr_en_q;
    assign dbg_addr  = addr_q;
    assign dbg_instr = instr_q;

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Sits directly upstream of the CPU core and drives its instruction-memory debug write port (dbg_wr_en/dbg_addr/dbg_instr).
- Owns the core's reset (cpu_rst) so the core never runs while its program is being written.
- Accepts a byte stream over a valid/ready handshake: a 4-byte little-endian word count N, then N little-endian instruction words. Each word is written to consecutive word addresses from BASE_ADDR.
- After the last write and a fixed hold interval, it releases the core's reset.

Parameters:
XLEN, 32, instruction/address width; byte assembly assumes XLEN=32.
BASE_ADDR, 0, byte address of the first instruction written.
MAX_WORDS, 1024, largest accepted N; a larger N is an error.
RST_HOLD, 4, cycles cpu_rst stays high after the final write (>=1).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_valid  in  1  byte valid
s_data  in  8  byte
s_ready  out  1  loader can accept a byte
reload  in  1  single-cycle pulse; restarts loading from RUN or ERROR
dbg_wr_en  out  1  instruction-memory write strobe to the core
dbg_addr  out  XLEN  write byte address
dbg_instr  out  XLEN  write data
cpu_rst  out  1  reset to the core, active-high
load_done  out  1  high in RUN
load_err  out  1  high in ERROR

Behaviour:
- Reset values:
  - state=HDR, s_ready=0, dbg_wr_en=0, dbg_addr=BASE_ADDR, dbg_instr=0.
  - cpu_rst=1, load_done=0, load_err=0.
  - Byte counter, word counter and hold counter all 0.
- Reset applied mid-operation aborts everything and returns to the reset state. A partial word is discarded.
- Handshake: a byte is accepted when s_valid && s_ready at a rising clock edge. s_ready is a registered function of state: 1 in HDR, LOAD and CSUM; 0 elsewhere. s_ready is 0 in the first cycle after reset.
- HDR:
  - Assembles N from 4 bytes, first byte = bits 7:0.
  - After the 4th byte:
    - N > MAX_WORDS -> ERROR.
    - N == 0 -> HOLD (or CSUM if the feature is enabled).
    - else -> LOAD.
- LOAD:
  - Assembles words little-endian. The cycle after the 4th byte of a word is accepted, the loader pulses dbg_wr_en for exactly 1 cycle with dbg_instr = the assembled word and dbg_addr = BASE_ADDR + 4*k, where k = word index starting at 0.
  - dbg_addr/dbg_instr hold their values until the next write.
  - Accepting a byte in the same cycle as a write strobe is allowed: full throughput is 1 byte/cycle.
  - After word N-1 -> HOLD (or CSUM).
- Arithmetic: addresses are XLEN-bit and wrap modulo 2^XLEN without error. The word counter is sized clog2(MAX_WORDS+1).
- HOLD: cpu_rst=1; counts RST_HOLD cycles starting after the final dbg_wr_en, then -> RUN.
- RUN: cpu_rst=0, load_done=1. Bytes are not accepted. reload -> HDR with cpu_rst=1 the next cycle and counters and address cleared.
- ERROR: cpu_rst=1, load_err=1, s_ready=0. Only reload or rst leave this state.
- reload in HDR, LOAD, CSUM or HOLD is ignored.
- Simultaneous rst and reload: rst wins.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the last word (or after the header when N=0), state CSUM accepts 4 more little-endian bytes.
  - They are compared with the modulo-2^32 sum of all N words written.
  - Match -> HOLD; mismatch -> ERROR.
  - No extra writes are issued.
- Undefined: the CSUM state, the accumulator and the comparison are absent; LOAD/HDR go directly to HOLD.

Decomposition:
- Package imem_loader_pkg:
  - State enum loader_state_t {HDR, LOAD, CSUM, HOLD, RUN, ERROR}.
  - Localparam for bytes per word (4).
  - Word-assembly helper function.
- One sub-module, loader_byte_packer: shifts in 4 accepted bytes and emits a word plus a 1-cycle word_valid.
- The FSM, counters and checksum stay in the top module.

Test Plan:
- Stream 02 00 00 00, 13 05 10 00, 93 05 20 00 at 1 byte/cycle -> writes (0x0,0x00100513) then (0x4,0x00200593), each dbg_wr_en 1 cycle wide. cpu_rst falls exactly RST_HOLD=4 cycles after the second strobe; load_done=1.
- Header 00 00 00 00 -> no writes, cpu_rst falls 4 cycles after the header, load_done=1.
- Header N=1025 with MAX_WORDS=1024 -> load_err=1, s_ready=0, cpu_rst stays 1. reload then N=1 header and word 0xDEADBEEF -> write (0x0,0xDEADBEEF), then RUN.
- Random s_valid gaps with N=3 -> identical writes and addresses 0x0, 0x4, 0x8. Assert rst after 6 payload bytes -> no further writes, state HDR, cpu_rst=1.
- In RUN, pulse reload, then load N=1 word 0x00000013 -> cpu_rst rises the next cycle, write (BASE_ADDR, 0x00000013), cpu_rst released after hold.
- With LOADER_CHECKSUM_EN: words 0x1, 0x2 plus checksum 03 00 00 00 -> RUN. Checksum 04 00 00 00 -> ERROR, load_err=1.
